// File: rtl/idft_cap_pkg.sv
// Shared defaults and types for the IDFT output capture stage.
package idft_cap_pkg;
  localparam int unsigned WORD_W       = 16;
  localparam int unsigned LANES        = 4;
  localparam int unsigned FRAME_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DROP    = 2'd2
  } cap_state_e;

  typedef logic [LANES*WORD_W-1:0] beat_t;
endpackage

// File: rtl/idft_cap_bank.sv
// One frame store: synchronous write port, combinational read port.
module idft_cap_bank #(
  parameter int unsigned WIDTH = idft_cap_pkg::LANES * idft_cap_pkg::WORD_W,
  parameter int unsigned DEPTH = idft_cap_pkg::FRAME_CYCLES,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/idft_output_capture.sv
// Captures IDFT output frames into a ping-pong buffer and replays them
// in capture order on a valid/ready stream; drops and errors are flagged.
module idft_output_capture #(
  parameter int unsigned WORD_W       = idft_cap_pkg::WORD_W,
  parameter int unsigned LANES        = idft_cap_pkg::LANES,
  parameter int unsigned FRAME_CYCLES = idft_cap_pkg::FRAME_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    next_out,
  input  logic [WORD_W-1:0]       Y0,
  input  logic [WORD_W-1:0]       Y1,
  input  logic [WORD_W-1:0]       Y2,
  input  logic [WORD_W-1:0]       Y3,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES*WORD_W-1:0] m_data,
  output logic                    m_last,
  input  logic                    clear_flags,
  output logic                    overflow,
  output logic                    protocol_err,
  output logic [7:0]              frames_dropped
);
  import idft_cap_pkg::*;

  localparam int unsigned BEAT_W = LANES * WORD_W;
  localparam int unsigned IDX_W  = $clog2(FRAME_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_CYCLES - 1);

  cap_state_e       state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] rd_idx_q;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic             overflow_q, protocol_err_q;
  logic [7:0]       drop_cnt_q;

  logic             push, drop_ev, err_ev, frame_end, rd_fire, rd_done;
  logic [1:0]       free_c, full_after_free;
  logic [BEAT_W-1:0] bank_rd [2];

  for (genvar i = 0; i < 2; i++) begin : g_bank
    idft_cap_bank #(.WIDTH(BEAT_W), .DEPTH(FRAME_CYCLES)) u_bank (
      .clk     (clk),
      .wr_en   ((state_q == CAPTURE) && (wr_bank_q == 1'(i))),
      .wr_idx  (wr_idx_q),
      .wr_data ({Y3, Y2, Y1, Y0}),
      .rd_idx  (rd_idx_q),
      .rd_data (bank_rd[i])
    );
  end

  assign m_valid        = full_q[rd_bank_q];
  assign m_last         = m_valid && (rd_idx_q == LAST_IDX);
  assign m_data         = m_valid ? bank_rd[rd_bank_q] : '0;
  assign rd_fire        = m_valid && m_ready;
  assign rd_done        = rd_fire && (rd_idx_q == LAST_IDX);
  assign frame_end      = (state_q != IDLE) && (wr_idx_q == LAST_IDX);
  assign overflow       = overflow_q;
  assign protocol_err   = protocol_err_q;
  assign frames_dropped = drop_cnt_q;

  // Capture FSM; a strobe on the final frame cycle restarts with no bubble.
  always_comb begin
    state_d         = state_q;
    wr_idx_d        = wr_idx_q;
    wr_bank_d       = wr_bank_q;
    push            = 1'b0;
    drop_ev         = 1'b0;
    err_ev          = 1'b0;
    full_d          = full_q;
    rd_bank_d       = rd_bank_q;
    free_c          = 2'b00;
    full_after_free = 2'b00;

    case (state_q)
      CAPTURE, DROP: begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
        if (frame_end) begin
          wr_idx_d = '0;
          state_d  = IDLE;
          push     = (state_q == CAPTURE);
        end else if (next_out) begin
          err_ev = 1'b1;
        end
      end
      default: ;
    endcase

    // A bank freed this cycle is reusable; one being filled this cycle is not.
    free_c = ~full_q & ~(push ? (2'b01 << wr_bank_q) : 2'b00);
    if (rd_done) free_c = free_c | (2'b01 << rd_bank_q);

    if (next_out && ((state_q == IDLE) || frame_end)) begin
      wr_idx_d = '0;
      if (free_c != 2'b00) begin
        state_d   = CAPTURE;
        wr_bank_d = ~free_c[0];
      end else begin
        state_d = DROP;
        drop_ev = 1'b1;
      end
    end

    // rd_bank always points at the oldest full bank.
    full_after_free = full_q & ~(rd_done ? (2'b01 << rd_bank_q) : 2'b00);
    full_d          = full_after_free | (push ? (2'b01 << wr_bank_q) : 2'b00);
    if (push && (full_after_free == 2'b00)) rd_bank_d = wr_bank_q;
    else if (rd_done)                       rd_bank_d = ~rd_bank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      if (rd_fire) rd_idx_q <= rd_done ? '0 : rd_idx_q + IDX_W'(1);
    end
  end

  // Sticky flags; a coincident event beats clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
      drop_cnt_q     <= 8'd0;
    end else begin
      if (drop_ev)          overflow_q <= 1'b1;
      else if (clear_flags) overflow_q <= 1'b0;
      if (err_ev)           protocol_err_q <= 1'b1;
      else if (clear_flags) protocol_err_q <= 1'b0;
      if (drop_ev) begin
        if (clear_flags)               drop_cnt_q <= 8'd1;
        else if (drop_cnt_q != 8'hFF)  drop_cnt_q <= drop_cnt_q + 8'd1;
      end else if (clear_flags) begin
        drop_cnt_q <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_idft_output_capture.sv
// Scoreboard bench: stimulus pushes expected beats, a monitor pops and compares.
module tb_idft_output_capture;
  logic        clk = 1'b0;
  logic        reset, next_out, m_valid, m_ready, m_last, clear_flags;
  logic        overflow, protocol_err;
  logic [15:0] Y0, Y1, Y2, Y3;
  logic [63:0] m_data;
  logic [7:0]  frames_dropped;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t        expq[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          beats_seen = 0;
  logic [63:0] held_d;
  logic        held_l;
  bit          stalled = 1'b0;

  always #5 clk = ~clk;

  idft_output_capture dut (
    .clk(clk), .reset(reset), .next_out(next_out),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .clear_flags(clear_flags), .overflow(overflow),
    .protocol_err(protocol_err), .frames_dropped(frames_dropped)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [63:0] beat(input int fid, input int k);
    logic [15:0] b;
    b = 16'(fid * 256 + 16 * k);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  // Monitor: pops on handshake, checks stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", m_data, held_d);
        check("stall_last", 64'(m_last), 64'(held_l));
      end
      stalled = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          if (expq.size() == 0) begin
            check("unexpected_beat", m_data, 64'd0);
          end else begin
            exp_t e;
            e = expq.pop_front();
            check("beat_data", m_data, e.d);
            check("beat_last", 64'(m_last), 64'(e.l));
          end
          beats_seen++;
        end else begin
          stalled = 1'b1;
          held_d  = m_data;
          held_l  = m_last;
        end
      end
    end
  end

  // Issue n frames back-to-back; the first `keep` are expected at the output.
  task automatic frames(input int n, input int fid0, input int keep, input int err_at);
    @(posedge clk); #1;
    next_out = 1'b1;
    for (int f = 0; f < n; f++) begin
      if (f < keep) begin
        for (int k = 0; k < 16; k++) begin
          exp_t e;
          e.d = beat(fid0 + f, k);
          e.l = (k == 15);
          expq.push_back(e);
        end
      end
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        {Y3, Y2, Y1, Y0} = beat(fid0 + f, k);
        next_out = (k == 15 && f < n - 1) || (f == 0 && k == err_at);
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (expq.size() != 0 && c < budget) begin
      @(posedge clk); c++;
    end
    check(name, 64'(expq.size()), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_idle"}, 64'(m_valid), 64'd0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clear_flags = 1'b1;
    @(posedge clk); #1; clear_flags = 1'b0;
    @(negedge clk);
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_protocol_err", 64'(protocol_err), 64'd0);
    check("clr_frames_dropped", 64'(frames_dropped), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c, base;
    reset = 1'b1; next_out = 1'b0; m_ready = 1'b0; clear_flags = 1'b0;
    {Y3, Y2, Y1, Y0} = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_protocol_err", 64'(protocol_err), 64'd0);
    check("rst_frames_dropped", 64'(frames_dropped), 64'd0);
    @(posedge clk); #1; reset = 1'b0;

    // Single frame: first beat at T+17.
    m_ready = 1'b1;
    frames(1, 1, 1, -1);
    @(negedge clk);
    check("valid_before_t17", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("valid_at_t17", 64'(m_valid), 64'd1);
    wait_drain("single_drain", 40);

    // Three back-to-back frames, full throughput.
    frames(3, 2, 3, -1);
    wait_drain("b2b_drain", 20);
    check("b2b_overflow", 64'(overflow), 64'd0);
    check("b2b_protocol_err", 64'(protocol_err), 64'd0);

    // Overflow: third frame dropped while stalled.
    m_ready = 1'b0;
    frames(3, 5, 2, -1);
    @(negedge clk);
    check("ovf_overflow", 64'(overflow), 64'd1);
    check("ovf_frames_dropped", 64'(frames_dropped), 64'd1);
    check("ovf_protocol_err", 64'(protocol_err), 64'd0);
    check("ovf_valid_held", 64'(m_valid), 64'd1);
    @(posedge clk); #1; m_ready = 1'b1;
    wait_drain("ovf_drain", 60);
    pulse_clear();

    // Random backpressure over two frames.
    fork
      frames(2, 8, 2, -1);
      begin
        repeat (90) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    wait_drain("bp_drain", 80);
    check("bp_overflow", 64'(overflow), 64'd0);

    // Protocol error mid-capture; frame must remain intact.
    frames(1, 10, 1, 5);
    @(negedge clk);
    check("perr_protocol_err", 64'(protocol_err), 64'd1);
    check("perr_overflow", 64'(overflow), 64'd0);
    wait_drain("perr_drain", 40);
    check("perr_state_idle", 64'(m_valid), 64'd0);
    pulse_clear();

    // Reset after beat 7 of a frame.
    base = beats_seen;
    frames(1, 12, 1, -1);
    c = 0;
    while (beats_seen < base + 8 && c < 40) begin
      @(posedge clk); #1; c++;
    end
    check("reach_beat7", 64'(beats_seen - base), 64'd8);
    reset = 1'b1; m_ready = 1'b0;
    expq.delete();
    @(posedge clk);
    @(negedge clk);
    check("rstmid_m_valid", 64'(m_valid), 64'd0);
    check("rstmid_m_last", 64'(m_last), 64'd0);
    @(posedge clk); #1; reset = 1'b0; m_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rstmid_no_beat", 64'(m_valid), 64'd0);
    frames(1, 13, 1, -1);
    wait_drain("rstmid_drain", 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
